// File: rtl/fft_pkg.sv
// Shared FFT datapath types and arithmetic helpers.
// Helpers work on a 64-bit signed carrier; callers slice the result.
package fft_pkg;

  localparam int DW_DEF = 16;
  localparam int TW_DEF = 16;
  localparam int XW     = 64;

  typedef logic signed [XW-1:0] wide_t;

  typedef struct packed {
    logic signed [DW_DEF-1:0] re;
    logic signed [DW_DEF-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [TW_DEF-1:0] re;
    logic signed [TW_DEF-1:0] im;
  } cplx_tw_t;

  function automatic wide_t rnd_shr(
    input wide_t       x,
    input int unsigned n
  );
    if (n == 0) return x;
    return (x + (64'sd1 <<< (n - 1))) >>> n;
  endfunction

  function automatic wide_t sat(
    input  wide_t       x,
    input  int unsigned dw,
    output logic        ovf
  );
    wide_t hi;
    wide_t lo;
    hi  = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (dw - 1));
    ovf = 1'b0;
    if (x > hi) begin
      ovf = 1'b1;
      return hi;
    end
    if (x < lo) begin
      ovf = 1'b1;
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/fft_bfly_pipe_if.sv
// Operand/result bundle of the butterfly with its handshakes.
// master = producer/consumer side, slave = butterfly side.
interface fft_bfly_pipe_if
  import fft_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int TW = TW_DEF
);

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_scale;
  logic signed [DW-1:0] a_re;
  logic signed [DW-1:0] a_im;
  logic signed [DW-1:0] b_re;
  logic signed [DW-1:0] b_im;
  logic signed [TW-1:0] w_re;
  logic signed [TW-1:0] w_im;

  logic                 out_valid;
  logic                 out_ready;
  logic                 ovf;
  logic signed [DW-1:0] y0_re;
  logic signed [DW-1:0] y0_im;
  logic signed [DW-1:0] y1_re;
  logic signed [DW-1:0] y1_im;

  modport master (
    output in_valid,
    output in_scale,
    output a_re,
    output a_im,
    output b_re,
    output b_im,
    output w_re,
    output w_im,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  ovf,
    input  y0_re,
    input  y0_im,
    input  y1_re,
    input  y1_im
  );

  modport slave (
    input  in_valid,
    input  in_scale,
    input  a_re,
    input  a_im,
    input  b_re,
    input  b_im,
    input  w_re,
    input  w_im,
    input  out_ready,
    output in_ready,
    output out_valid,
    output ovf,
    output y0_re,
    output y0_im,
    output y1_re,
    output y1_im
  );

endinterface

// File: rtl/fft_cmul.sv
// Two-stage complex multiply t = b*w with round-half-up to DW+2 bits.
// Carries an opaque sideband alongside so callers can align operands.
module fft_cmul
  import fft_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int TW  = TW_DEF,
  parameter int SBW = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic                 valid_i,
  input  logic signed [DW-1:0] b_re_i,
  input  logic signed [DW-1:0] b_im_i,
  input  logic signed [TW-1:0] w_re_i,
  input  logic signed [TW-1:0] w_im_i,
  input  logic [SBW-1:0]       side_i,
  output logic                 valid_o,
  output logic signed [DW+1:0] t_re_o,
  output logic signed [DW+1:0] t_im_o,
  output logic [SBW-1:0]       side_o
);

  localparam int PW = DW + TW;
  localparam int SW = PW + 1;
  localparam int RW = DW + 2;

  typedef struct packed {
    logic signed [PW-1:0] rr;
    logic signed [PW-1:0] ii;
    logic signed [PW-1:0] ri;
    logic signed [PW-1:0] ir;
  } prod_t;

  prod_t                p_d;
  prod_t                p_q;
  logic                 v1_q;
  logic                 v2_q;
  logic [SBW-1:0]       sb1_q;
  logic [SBW-1:0]       sb2_q;
  logic signed [SW-1:0] sum_re;
  logic signed [SW-1:0] sum_im;
  logic signed [RW-1:0] t_re_d;
  logic signed [RW-1:0] t_im_d;
  logic signed [RW-1:0] t_re_q;
  logic signed [RW-1:0] t_im_q;

  always_comb begin
    p_d.rr = PW'(b_re_i) * PW'(w_re_i);
    p_d.ii = PW'(b_im_i) * PW'(w_im_i);
    p_d.ri = PW'(b_re_i) * PW'(w_im_i);
    p_d.ir = PW'(b_im_i) * PW'(w_re_i);
  end

  // Full-precision sums need one guard bit; Q1.(TW-1) scaling drops TW-1.
  always_comb begin
    sum_re = SW'($signed(p_q.rr)) - SW'($signed(p_q.ii));
    sum_im = SW'($signed(p_q.ri)) + SW'($signed(p_q.ir));
    t_re_d = RW'(rnd_shr(wide_t'(sum_re), TW - 1));
    t_im_d = RW'(rnd_shr(wide_t'(sum_im), TW - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      p_q   <= '0;
      sb1_q <= '0;
    end else if (en_i) begin
      v1_q  <= valid_i;
      p_q   <= p_d;
      sb1_q <= side_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q   <= 1'b0;
      t_re_q <= '0;
      t_im_q <= '0;
      sb2_q  <= '0;
    end else if (en_i) begin
      v2_q   <= v1_q;
      t_re_q <= t_re_d;
      t_im_q <= t_im_d;
      sb2_q  <= sb1_q;
    end
  end

  assign valid_o = v2_q;
  assign t_re_o  = t_re_q;
  assign t_im_o  = t_im_q;
  assign side_o  = sb2_q;

endmodule

// File: rtl/fft_bfly_pipe.sv
// Radix-2 DIT butterfly: y0 = a + b*w, y1 = a - b*w, three stages.
// Whole pipe freezes while a result waits on out_ready.
module fft_bfly_pipe
  import fft_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int TW  = TW_DEF,
  parameter int SAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  fft_bfly_pipe_if.slave bus,
  input  logic           ovf_clr,
  output logic           ovf_sticky
);

  localparam int SX = DW + 3;

  typedef struct packed {
    logic                 scale;
    logic signed [DW-1:0] a_re;
    logic signed [DW-1:0] a_im;
  } side_t;

  side_t                side_in;
  side_t                side_s2;
  logic                 stall;
  logic                 en;
  logic                 v2;
  logic signed [DW+1:0] t_re;
  logic signed [DW+1:0] t_im;

  logic signed [SX-1:0] sum_d  [4];
  wide_t                scl_d  [4];
  logic signed [DW-1:0] y_d    [4];
  logic signed [DW-1:0] y_q    [4];
  logic [3:0]           cov;
  logic                 ovf_d;
  logic                 ovf_q;
  logic                 ov_q;
  logic                 fire;
  logic                 sticky_d;
  logic                 sticky_q;

  assign stall        = ov_q && !bus.out_ready;
  assign en           = !stall;
  assign fire         = ov_q && bus.out_ready;
  assign bus.in_ready = en;

  always_comb begin
    side_in.scale = bus.in_scale;
    side_in.a_re  = bus.a_re;
    side_in.a_im  = bus.a_im;
  end

  fft_cmul #(
    .DW  (DW),
    .TW  (TW),
    .SBW ($bits(side_t))
  ) u_cmul (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (en),
    .valid_i (bus.in_valid),
    .b_re_i  (bus.b_re),
    .b_im_i  (bus.b_im),
    .w_re_i  (bus.w_re),
    .w_im_i  (bus.w_im),
    .side_i  (side_in),
    .valid_o (v2),
    .t_re_o  (t_re),
    .t_im_o  (t_im),
    .side_o  (side_s2)
  );

  always_comb begin
    sum_d[0] = SX'($signed(side_s2.a_re)) + SX'(t_re);
    sum_d[1] = SX'($signed(side_s2.a_im)) + SX'(t_im);
    sum_d[2] = SX'($signed(side_s2.a_re)) - SX'(t_re);
    sum_d[3] = SX'($signed(side_s2.a_im)) - SX'(t_im);
  end

  // ovf is raised in wrap mode too, so the flag means "out of range".
  always_comb begin
    cov = '0;
    for (int k = 0; k < 4; k++) begin
      scl_d[k] = wide_t'(sum_d[k]);
      y_d[k]   = '0;
    end
    for (int k = 0; k < 4; k++) begin
      if (side_s2.scale) begin
        scl_d[k] = rnd_shr(wide_t'(sum_d[k]), 1);
      end
      y_d[k] = DW'(sat(scl_d[k], DW, cov[k]));
      if (SAT == 0) begin
        y_d[k] = DW'(scl_d[k]);
      end
    end
    ovf_d = |cov;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q  <= 1'b0;
      ovf_q <= 1'b0;
      y_q   <= '{default: '0};
    end else if (en) begin
      ov_q  <= v2;
      ovf_q <= v2 && ovf_d;
      y_q   <= y_d;
    end
  end

  always_comb begin
    sticky_d = sticky_q;
    priority case (1'b1)
      ovf_clr:        sticky_d = 1'b0;
      fire && ovf_q:  sticky_d = 1'b1;
      default:        ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.ovf       = ovf_q;
  assign bus.y0_re     = y_q[0];
  assign bus.y0_im     = y_q[1];
  assign bus.y1_re     = y_q[2];
  assign bus.y1_im     = y_q[3];
  assign ovf_sticky    = sticky_q;

endmodule

// File: tb/tb_fft_bfly_pipe.sv
// Bench for fft_bfly_pipe: integer butterfly model plus directed vectors.
// Inputs driven 1 time unit after posedge; outputs sampled on negedge.
module tb_fft_bfly_pipe;
  import fft_pkg::*;

  localparam int DW = 16;
  localparam int TW = 16;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic ovf_clr = 1'b0;
  logic ovf_sticky;

  fft_bfly_pipe_if #(.DW(DW), .TW(TW)) bus ();

  fft_bfly_pipe #(
    .DW  (DW),
    .TW  (TW),
    .SAT (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .ovf_clr    (ovf_clr),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint y[4];
    bit     ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   passed    = 0;
  int   out_count = 0;
  int   rdy_low   = 0;
  int   vld_seen  = 0;

  task automatic chk(string nm, longint act, longint req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, required %0d", nm, act, req);
  endtask

  function automatic longint fdiv(longint x, longint d);
    longint q;
    q = x / d;
    if ((x % d != 0) && (x < 0)) q = q - 1;
    return q;
  endfunction

  function automatic exp_t model(longint ar, longint ai, longint br,
                                 longint bi, longint wr, longint wi,
                                 bit sc);
    exp_t   e;
    longint tr;
    longint ti;
    tr = fdiv(br * wr - bi * wi + 16384, 32768);
    ti = fdiv(br * wi + bi * wr + 16384, 32768);
    e.y[0] = ar + tr;
    e.y[1] = ai + ti;
    e.y[2] = ar - tr;
    e.y[3] = ai - ti;
    e.ovf  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (sc) e.y[k] = fdiv(e.y[k] + 1, 2);
      if (e.y[k] > 32767) begin
        e.y[k] = 32767;
        e.ovf  = 1'b1;
      end else if (e.y[k] < -32768) begin
        e.y[k] = -32768;
        e.ovf  = 1'b1;
      end
    end
    return e;
  endfunction

  always @(negedge rst_n) exp_q.delete();

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.a_re, bus.a_im, bus.b_re, bus.b_im,
                              bus.w_re, bus.w_im, bus.in_scale));
      chk("in_ready_vs_stall", bus.in_ready,
          !(bus.out_valid && !bus.out_ready));
      if (!bus.in_ready) rdy_low++;
      if (bus.out_valid) begin
        vld_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          e = exp_q[0];
          chk("model_y0_re", bus.y0_re, e.y[0]);
          chk("model_y0_im", bus.y0_im, e.y[1]);
          chk("model_y1_re", bus.y1_re, e.y[2]);
          chk("model_y1_im", bus.y1_im, e.y[3]);
          chk("model_ovf", bus.ovf, e.ovf);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            out_count++;
          end
        end
      end
    end
  end

  task automatic drive(int ar, int ai, int br, int bi, int wr, int wi,
                       bit sc);
    bus.a_re     = 16'(ar);
    bus.a_im     = 16'(ai);
    bus.b_re     = 16'(br);
    bus.b_im     = 16'(bi);
    bus.w_re     = 16'(wr);
    bus.w_im     = 16'(wi);
    bus.in_scale = sc;
    bus.in_valid = 1'b1;
  endtask

  // One transaction; returns on the negedge where its result is visible.
  task automatic single(string nm, int ar, int ai, int br, int bi,
                        int wr, int wi, bit sc, int e0r, int e0i,
                        int e1r, int e1i, bit eo);
    @(posedge clk); #1;
    drive(ar, ai, br, bi, wr, wi, sc);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_lat1_valid"}, bus.out_valid, 0);
    @(negedge clk);
    chk({nm, "_lat2_valid"}, bus.out_valid, 0);
    @(negedge clk);
    chk({nm, "_lat3_valid"}, bus.out_valid, 1);
    chk({nm, "_y0_re"}, bus.y0_re, e0r);
    chk({nm, "_y0_im"}, bus.y0_im, e0i);
    chk({nm, "_y1_re"}, bus.y1_re, e1r);
    chk({nm, "_y1_im"}, bus.y1_im, e1i);
    chk({nm, "_ovf"}, bus.ovf, eo);
  endtask

  task automatic stream();
    int  i;
    int  guard;
    int  base;
    bit  acc;
    base    = out_count;
    rdy_low = 0;
    fork
      begin
        i     = 0;
        guard = 0;
        @(posedge clk); #1;
        drive(1, 0, 100, -50, 23170, -23170, 1'b0);
        while (i < 8 && guard < 100) begin
          @(negedge clk);
          acc = bus.in_ready;
          @(posedge clk); #1;
          guard++;
          if (acc) begin
            i++;
            if (i < 8)
              drive(i + 1, -i, 100 * (i + 1), -50 * (i + 1),
                    23170, -23170, 1'(i % 2));
            else
              bus.in_valid = 1'b0;
          end
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) @(negedge clk);
    chk("stream_drained", exp_q.size(), 0);
    chk("stream_out_count", out_count - base, 8);
    chk("stream_in_ready_low_cycles", rdy_low, 3);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int v0;
    bus.in_valid  = 1'b0;
    bus.in_scale  = 1'b0;
    bus.out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1'b0);
    bus.in_valid  = 1'b0;

    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_sticky", ovf_sticky, 0);
    chk("rst_y0_re", bus.y0_re, 0);
    chk("rst_y1_im", bus.y1_im, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    single("t1", 100, 0, 50, 0, 32767, 0, 1'b0, 150, 0, 50, 0, 1'b0);
    single("t2", 0, 0, 10, 20, 0, -32768, 1'b0, 20, -10, -20, 10, 1'b0);

    single("t3", 32767, 0, 32767, 0, 32767, 0, 1'b0,
           32767, 0, 1, 0, 1'b1);
    chk("t3_sticky_before", ovf_sticky, 0);
    @(negedge clk);
    chk("t3_sticky_after", ovf_sticky, 1);

    single("t4", 32767, 0, 32767, 0, 32767, 0, 1'b1,
           32767, 0, 1, 0, 1'b0);
    @(negedge clk);
    chk("t4_sticky_kept", ovf_sticky, 1);
    single("t4clr", 32767, 0, 32767, 0, 32767, 0, 1'b0,
           32767, 0, 1, 0, 1'b1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("t4_clr_wins", ovf_sticky, 0);

    stream();

    single("bnd", 0, 0, -32768, 0, -32768, 0, 1'b0,
           32767, 0, -32768, 0, 1'b1);
    single("bnd_sc", 0, 0, -32768, 0, -32768, 0, 1'b1,
           16384, 0, -16384, 0, 1'b0);
    @(negedge clk);
    chk("bnd_sticky", ovf_sticky, 1);

    @(posedge clk); #1;
    drive(32767, 0, 32767, 0, 32767, 0, 1'b0);
    @(posedge clk); #1;
    drive(100, 0, 50, 0, 32767, 0, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_pre_valid", bus.out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", bus.out_valid, 0);
    chk("t6_async_ovf", bus.ovf, 0);
    chk("t6_async_sticky", ovf_sticky, 0);
    chk("t6_async_in_ready", bus.in_ready, 1);
    #1 rst_n = 1'b1;
    v0 = vld_seen;
    repeat (8) @(negedge clk);
    chk("t6_no_output_after_release", vld_seen - v0, 0);
    single("t6", 100, 0, 50, 0, 32767, 0, 1'b0, 150, 0, 50, 0, 1'b0);
    @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
